// File: rtl/fixed_point_divider_pkg.sv
// rtl/fixed_point_divider_pkg.sv - shared state encoding and Q-format constants for the divider
//
// Purpose: state encoding for the sequential divider plus default width-derived
// constants used by the divider and the rest of the interpolation datapath.
// Ports: none (package).

package fixed_point_divider_pkg;

    // Default datapath format: Q7.8 in 16 bits.
    localparam int DIV_WIDTH = 16;
    localparam int DIV_FRAC  = 8;

    // Quotient bits produced by the restoring loop, one per CALC cycle.
    localparam int DIV_ITER = DIV_WIDTH + DIV_FRAC;

    // Saturation limits at the default width.
    localparam logic [DIV_WIDTH-1:0] DIV_MAX_POS = {1'b0, {(DIV_WIDTH-1){1'b1}}};
    localparam logic [DIV_WIDTH-1:0] DIV_MAX_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    // Format constants shared with the interpolation adder/multiplier.
    localparam int                   Q_INT_BITS = DIV_WIDTH - DIV_FRAC - 1;
    localparam logic [DIV_WIDTH-1:0] Q_ONE      = DIV_WIDTH'(1) << DIV_FRAC;
    localparam logic [DIV_WIDTH-1:0] Q_HALF     = DIV_WIDTH'(1) << (DIV_FRAC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/fixed_point_divider.sv
// rtl/fixed_point_divider.sv - sequential signed Q-format radix-2 restoring divider
//
// Purpose: computes quotient = dividend / divisor in Q(WIDTH-FRAC-1).FRAC,
// one quotient bit per cycle, truncated toward zero with saturation.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, honoured only in IDLE
//   dividend, divisor   operands, captured on an accepted start
//   quotient            result, held until the next accepted start
//   done                one-cycle completion pulse
//   busy                high while CALC or FIX
//   div_by_zero         divisor was zero (held with quotient)
//   overflow            result saturated (held with quotient)

module fixed_point_divider
    import fixed_point_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int FRAC  = DIV_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int NW = WIDTH + FRAC;
    localparam int CW = $clog2(NW + 1);

    localparam logic [WIDTH-1:0] Q_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    // Magnitude limits for the two result signs, at numerator width.
    localparam logic [NW-1:0] POS_LIM = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [NW-1:0] NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic             sign_q;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] rem;
    // Holds the remaining numerator bits at the top and collects quotient
    // bits at the bottom; after NW steps it is exactly the magnitude Qm.
    logic [NW-1:0]    num;
    logic [CW-1:0]    cnt;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit number.
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;

    assign dvd_mag_in = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_mag_in = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    // Restoring step: the shifted remainder needs one extra bit because it
    // can reach 2*|divisor|-1 before the compare.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [NW-1:0]    num_next;

    assign rem_shift = {rem, num[NW-1]};
    assign rem_ge    = rem_shift >= {1'b0, dvsr_mag};
    // Only used when rem_ge, so the result always fits in WIDTH bits.
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvsr_mag;
    assign rem_next  = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
    assign num_next  = {num[NW-2:0], rem_ge};

    // Sign application and saturation of the final magnitude.
    logic [WIDTH-1:0] fix_q;
    logic             fix_ov;

    always_comb begin
        fix_q  = '0;
        fix_ov = 1'b0;
        if (!sign_q) begin
            if (num > POS_LIM) begin
                fix_q  = Q_MAX_POS;
                fix_ov = 1'b1;
            end else begin
                fix_q = num[WIDTH-1:0];
            end
        end else begin
            if (num > NEG_LIM) begin
                fix_q  = Q_MAX_NEG;
                fix_ov = 1'b1;
            end else begin
                // Negating zero yields zero, so -0 never appears.
                fix_q = ~num[WIDTH-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sign_q      <= 1'b0;
            dvsr_mag    <= '0;
            rem         <= '0;
            num         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dvsr_mag    <= dvs_mag_in;
                        rem         <= '0;
                        num         <= {dvd_mag_in, {FRAC{1'b0}}};
                        cnt         <= CW'(NW);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= dividend[WIDTH-1] ? Q_MAX_NEG : Q_MAX_POS;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem <= rem_next;
                    num <= num_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient <= fix_q;
                    overflow <= fix_ov;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// tb/tb_fixed_point_divider.sv - self-checking bench for fixed_point_divider

module tb_fixed_point_divider;

    localparam int W    = 16;
    localparam int F    = 8;
    localparam int LAT  = W + F + 2;
    localparam int BOUND = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic         done;
    logic         busy;
    logic         div_by_zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    fixed_point_divider #(.WIDTH(W), .FRAC(F)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference: exact rational quotient truncated toward zero by integer
    // division, then clamped to the signed range.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic dz, output logic ov,
                           output int lat);
        longint sa, sb, qq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz  = 1'b1;
            q   = (sa >= 0) ? 16'h7FFF : 16'h8000;
            lat = 1;
        end else begin
            qq  = (sa * (longint'(1) << F)) / sb;
            lat = LAT;
            if (qq > 32767) begin
                q  = 16'h7FFF;
                ov = 1'b1;
            end else if (qq < -32768) begin
                q  = 16'h8000;
                ov = 1'b1;
            end else begin
                q = W'(qq);
            end
        end
    endtask

    // Drives one request and observes the result; performs no checking.
    // lat counts cycles after the start cycle; -1 if done never came.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic dz, output logic ov,
                          output int lat, output bit busy_ok);
        int k;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        busy_ok  = 1'b1;
        lat      = -1;
        q        = 'x;
        dz       = 1'bx;
        ov       = 1'bx;
        for (k = 1; k <= BOUND; k++) begin
            if (done === 1'b1) begin
                lat = k;
                q   = quotient;
                dz  = div_by_zero;
                ov  = overflow;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({quotient, done, busy, div_by_zero, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got q=%h done=%b busy=%b dz=%b ov=%b, want all 0",
                     quotient, done, busy, div_by_zero, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, eq;
        logic dz, ov, edz, eov;
        int lat, elat;
        bit busy_ok;
        ref_div(a, b, eq, edz, eov, elat);
        run_op(a, b, q, dz, ov, lat, busy_ok);
        total++;
        if (q !== eq || dz !== edz || ov !== eov) begin
            bad++;
            $display("FAIL %s %h/%h: got q=%h dz=%b ov=%b, want q=%h dz=%b ov=%b",
                     name, a, b, q, dz, ov, eq, edz, eov);
        end
        total++;
        if (lat !== elat || !busy_ok) begin
            bad++;
            $display("FAIL %s_timing %h/%h: got latency=%0d busy_ok=%0d, want latency=%0d busy_ok=1",
                     name, a, b, lat, busy_ok, elat);
        end
    endtask

    task automatic test_directed();
        check_vec("three_by_two", 16'h0300, 16'h0200);
        check_vec("neg_by_half",  16'hFF00, 16'h0080);
        check_vec("one_by_neg3",  16'h0100, 16'hFD00);
        check_vec("one_by_three", 16'h0100, 16'h0300);
        check_vec("zero_neg",     16'h0000, 16'hFD00);
    endtask

    task automatic test_div_zero();
        check_vec("dz_pos", 16'h0100, 16'h0000);
        check_vec("dz_neg", 16'hFF00, 16'h0000);
        check_vec("dz_zero", 16'h0000, 16'h0000);
    endtask

    task automatic test_boundary();
        check_vec("ovf_pos",     16'h7F00, 16'h0001);
        check_vec("min_by_one",  16'h8000, 16'h0100);
        check_vec("min_by_m1",   16'h8000, 16'hFF00);
        check_vec("ovf_neg",     16'h8000, 16'h0001);
        check_vec("max_by_max",  16'h7FFF, 16'h7FFF);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, eq;
        logic dz, ov, edz, eov;
        int lat, elat;
        bit busy_ok;
        int errs = 0;
        for (int i = 0; i < 150; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = W'($urandom_range(0, 3)) - 16'd1;
                1: b = W'($urandom_range(0, 511)) - 16'd256;
                default: b = W'($urandom);
            endcase
            ref_div(a, b, eq, edz, eov, elat);
            run_op(a, b, q, dz, ov, lat, busy_ok);
            total++;
            if (q !== eq || dz !== edz || ov !== eov || lat !== elat || !busy_ok) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random %h/%h: got q=%h dz=%b ov=%b lat=%0d busy_ok=%0d, want q=%h dz=%b ov=%b lat=%0d",
                             a, b, q, dz, ov, lat, busy_ok, eq, edz, eov, elat);
            end
        end
    endtask

    // Starts while busy and in the done cycle must both be ignored.
    task automatic test_ignored_start();
        logic [W-1:0] eq;
        logic edz, eov;
        int elat, lat;
        bit busy_ok;
        logic [W-1:0] q_done;
        logic dz_done, ov_done;
        bit extra_done;
        ref_div(16'h0300, 16'h0200, eq, edz, eov, elat);
        @(negedge clk);
        dividend = 16'h0300;
        divisor  = 16'h0200;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        q_done  = 'x;
        dz_done = 1'bx;
        ov_done = 1'bx;
        for (int k = 1; k <= BOUND; k++) begin
            if (k == 5) begin
                dividend = 16'h0100;
                divisor  = 16'h0000;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat     = k;
                q_done  = quotient;
                dz_done = div_by_zero;
                ov_done = overflow;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
        total++;
        if (lat !== elat || q_done !== eq || dz_done !== edz || ov_done !== eov || !busy_ok) begin
            bad++;
            $display("FAIL start_while_busy: got lat=%0d q=%h dz=%b ov=%b busy_ok=%0d, want lat=%0d q=%h dz=%b ov=%b",
                     lat, q_done, dz_done, ov_done, busy_ok, elat, eq, edz, eov);
        end
        // Start held during the done cycle with a divide-by-zero request.
        dividend = 16'hFF00;
        divisor  = 16'h0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        extra_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) extra_done = 1'b1;
            @(negedge clk);
        end
        total++;
        if (extra_done || quotient !== eq || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: got extra_activity=%0d q=%h dz=%b, want 0 q=%h dz=0",
                     extra_done, quotient, div_by_zero, eq);
        end
    endtask

    task automatic test_mid_reset();
        bit saw_done;
        logic [W-1:0] eq, q;
        logic edz, eov, dz, ov;
        int elat, lat;
        bit busy_ok;
        @(negedge clk);
        dividend = 16'h0700;
        divisor  = 16'h0300;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({quotient, done, busy, div_by_zero, overflow} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got q=%h done=%b busy=%b dz=%b ov=%b, want all 0",
                     quotient, done, busy, div_by_zero, overflow);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL mid_reset_no_done: got activity after abort, want none");
        end
        ref_div(16'h0700, 16'hFD00, eq, edz, eov, elat);
        run_op(16'h0700, 16'hFD00, q, dz, ov, lat, busy_ok);
        total++;
        if (q !== eq || dz !== edz || ov !== eov || lat !== elat || !busy_ok) begin
            bad++;
            $display("FAIL after_reset: got q=%h dz=%b ov=%b lat=%0d, want q=%h dz=%b ov=%b lat=%0d",
                     q, dz, ov, lat, eq, edz, eov, elat);
        end
    endtask

    task automatic test_done_pulse();
        logic [W-1:0] q;
        logic dz, ov;
        int lat;
        bit busy_ok;
        run_op(16'h0500, 16'h0200, q, dz, ov, lat, busy_ok);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || quotient !== q) begin
            bad++;
            $display("FAIL done_pulse: got done=%b q=%h after done cycle, want done=0 q=%h",
                     done, quotient, q);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_boundary();
        test_done_pulse();
        test_ignored_start();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
Sequential signed fixed-point divider for the interpolation datapath. The interpolation controller computes the step ratio m = (tk - tn) / (tz - tn): it pulses start_div and waits on divider_done. This block is that divider. It accepts two Q-format operands, runs radix-2 restoring division at one quotient bit per cycle, then applies sign and saturation. It pulses done with a held quotient and status flags.

Parameters:
WIDTH, 16, total operand/result width, two's complement
FRAC, 8, fractional bits; format Q(WIDTH-FRAC-1).FRAC for both operands and the result

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
dividend  in  WIDTH  numerator, captured on accepted start
divisor  in  WIDTH  denominator, captured on accepted start
quotient  out  WIDTH  result; valid from the done cycle, held until the next accepted start
done  out  1  one-cycle completion pulse (drives divider_done)
busy  out  1  high in every state except IDLE and DONE
div_by_zero  out  1  divisor was 0; held with quotient
overflow  out  1  result saturated; held with quotient

Behaviour:
- Interface: one clock (clk); rst is synchronous, active-high.
- Reset values:
  - All outputs 0; state IDLE.
  - Internal registers 0.
  - rst mid-operation aborts: next cycle is IDLE, no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, capture the operands, clear div_by_zero and overflow, and hold quotient at its old value until FIX.
  - divisor==0: next state DONE directly. Quotient is 0x7FF..F if dividend>=0, else 0x800..0. div_by_zero=1, overflow=0.
  - Otherwise: next state CALC.
  - Capture-time setup: sign = dividend[MSB] ^ divisor[MSB]. Magnitudes |dividend| and |divisor| are unsigned WIDTH bits (|0x80..0| is representable). Numerator N = |dividend| << FRAC, WIDTH+FRAC bits. Counter = WIDTH+FRAC.
- CALC, one bit per cycle:
  - Shift the remainder (WIDTH+1 bits) left and bring in the next MSB of N.
  - If remainder >= |divisor|, subtract and shift in 1; else shift in 0.
  - Decrement the counter; when it reaches 0, go to FIX.
  - Occupies exactly WIDTH+FRAC cycles.
- FIX (1 cycle):
  - The magnitude Qm (WIDTH+FRAC bits) is truncated toward zero.
  - Positive result: if Qm > 2^(WIDTH-1)-1, output 0x7F..F with overflow=1.
  - Negative result: if Qm > 2^(WIDTH-1), output 0x80..0 with overflow=1; otherwise output -Qm.
  - A zero quotient is +0 regardless of sign.
  - Register quotient and flags; next state DONE.
- DONE (1 cycle): done=1, next state IDLE. A start in DONE is ignored.
- Latency: start sampled in cycle T gives done in cycle T+WIDTH+FRAC+2 (T+26 at defaults). Divide-by-zero gives done in cycle T+1.
- start while busy: ignored; operands are not re-captured.
- Operand inputs may change after the start cycle without effect.

Decomposition:
- Shared package holds:
  - The state encoding localparams (IDLE/CALC/FIX/DONE).
  - Width-derived constants MAX_POS and MAX_NEG, plus the iteration count WIDTH+FRAC.
  - Format constants reused by the interpolation datapath adder/multiplier.
- No sub-module is required. The restoring-step compare/subtract is inline combinational logic of about 10 lines; the whole block stays in a single module of about 150-200 lines.

Test Plan:
- 0x0300 / 0x0200 (3.0/2.0) -> quotient 0x0180, done exactly 26 cycles after the start cycle, busy high for cycles T+1..T+25, flags 0.
- 0xFF00 / 0x0080 (-1.0/0.5) -> 0xFE00 (-2.0). 0x0100 / 0xFD00 (1.0/-3.0) -> 0xFFAB (truncated -85/256). 0x0100 / 0x0300 -> 0x0055.
- 0x0100 / 0x0000 -> 0x7FFF with div_by_zero=1 and done at T+1. 0xFF00 / 0x0000 -> 0x8000 with div_by_zero=1.
- Overflow and boundary cases:
  - 0x7F00 / 0x0001 -> 0x7FFF with overflow=1.
  - 0x8000 / 0x0100 (-128/1) -> 0x8000 with overflow=0.
  - 0x8000 / 0xFF00 (-128/-1) -> 0x7FFF with overflow=1.
- Second start pulsed at T+5 with different operands -> ignored; the first result arrives at T+26 unchanged. A start in the done cycle is also ignored.
- rst asserted at T+10 mid-CALC -> IDLE next cycle, quotient 0 and flags 0, no done. A fresh start afterwards completes normally.
